mccoy_prog_sequencer: RTL and testbench

- Run controller and program store that sequences the McCoy core.
- Holds a small program loaded over a valid/ready port, then supplies the 6-bit instruction for the core's PC every cycle.
- Owns the core's reset and clock-enable, which gives run / pause / single-step / auto-halt control.
- Sits between the test harness or host I/O and the core's instr input; core_pc is taken from the core's posedge io_out phase.

---
 rtl/mccoy_prog_sequencer.sv | 103 ++++++++++
 tb/tb_mccoy_prog_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mccoy_prog_sequencer.sv
// mccoy_prog_sequencer: program store and run controller for the McCoy core.
// Ports: load_valid/load_data/load_ready program load; start/stop/step run control;
//   core_pc in, core_instr/core_clk_en/core_reset to the core; busy/halted/cycle_cnt status.
// Optional: define MCCOY_SEQ_BREAKPOINT_EN to add bp_addr/bp_enable breakpoint ports.
module mccoy_prog_sequencer #(
  parameter int DEPTH = 32,
  parameter int AW = 5,
  parameter logic [5:0] FILL = 6'b000000,
  parameter int HALT_REPEAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [5:0]  load_data,
  output logic        load_ready,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic [7:0]  core_pc,
`ifdef MCCOY_SEQ_BREAKPOINT_EN
  input  logic [7:0]  bp_addr,
  input  logic        bp_enable,
`endif
  output logic [5:0]  core_instr,
  output logic        core_clk_en,
  output logic        core_reset,
  output logic        busy,
  output logic        halted,
  output logic [15:0] cycle_cnt
);
  typedef enum logic [2:0] {IDLE, CRST, RUN, PAUSE, STEP, HALT} state_t;
  state_t state_q;
  logic [AW:0] wr_ptr_q;
  logic [15:0] cycle_cnt_q;
  logic [7:0] same_cnt_q, prev_pc_q;
  logic [5:0] mem [DEPTH];
  logic exec, match, halt_hit, bp_hit;
  assign exec = state_q == RUN || state_q == STEP;
  assign match = core_pc == prev_pc_q;
  assign halt_hit = match && same_cnt_q == 8'(HALT_REPEAT - 1);
`ifdef MCCOY_SEQ_BREAKPOINT_EN
  // bp_skip_q suppresses a re-trigger after resuming until core_pc leaves bp_addr
  logic bp_skip_q;
  assign bp_hit = bp_enable && core_pc == bp_addr && !bp_skip_q;
  always_ff @(posedge clk)
    if (!reset) bp_skip_q <= 1'b0;
    else if (exec) bp_skip_q <= bp_hit || (bp_skip_q && core_pc == bp_addr);
`else
  assign bp_hit = 1'b0;
`endif
  assign load_ready = state_q == IDLE && wr_ptr_q != (AW+1)'(DEPTH);
  // pc below wr_ptr implies pc below DEPTH, so no separate range check is needed
  assign core_instr = (state_q == IDLE || state_q == CRST || {1'b0, core_pc} >= 9'(wr_ptr_q))
                      ? FILL : mem[core_pc[AW-1:0]];
  assign core_clk_en = state_q == CRST || exec;
  assign busy = core_clk_en;
  assign core_reset = state_q == IDLE || state_q == CRST;
  assign halted = state_q == HALT;
  assign cycle_cnt = cycle_cnt_q;
  always_ff @(posedge clk)
    if (reset && load_valid && load_ready) mem[wr_ptr_q[AW-1:0]] <= load_data;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      cycle_cnt_q <= '0;
      same_cnt_q <= '0;
      prev_pc_q <= '0;
    end else begin
      if (exec) begin
        cycle_cnt_q <= cycle_cnt_q + 16'(cycle_cnt_q != 16'hFFFF);
        same_cnt_q <= match ? same_cnt_q + 8'd1 : 8'd0;
        prev_pc_q <= core_pc;
      end
      case (state_q)
        IDLE: begin
          if (load_valid && load_ready) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
          if (start && wr_ptr_q != '0) begin
            state_q <= CRST;
            cycle_cnt_q <= '0;
          end
        end
        CRST: begin
          state_q <= RUN;
          same_cnt_q <= '0;
        end
        RUN: state_q <= (stop || bp_hit) ? PAUSE : halt_hit ? HALT : RUN;
        PAUSE: state_q <= stop ? IDLE : step ? STEP : start ? RUN : PAUSE;
        STEP: state_q <= halt_hit ? HALT : PAUSE;
        HALT: begin
          if (stop) begin
            state_q <= IDLE;
            wr_ptr_q <= '0;
          end else if (start) begin
            state_q <= CRST;
            cycle_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mccoy_prog_sequencer.sv
// tb_mccoy_prog_sequencer: scoreboard bench for the McCoy program sequencer.
module tb_mccoy_prog_sequencer;
  localparam logic [5:0] FILL = 6'b000000;
  logic clk = 1'b0, reset = 1'b0, load_valid = 1'b0, start = 1'b0, stop = 1'b0, step = 1'b0;
  logic [5:0] load_data = '0;
  logic [7:0] core_pc = '0;
  logic load_ready, core_clk_en, core_reset, busy, halted;
  logic [5:0] core_instr;
  logic [15:0] cycle_cnt;
`ifdef MCCOY_SEQ_BREAKPOINT_EN
  logic [7:0] bp_addr = '0;
  logic bp_enable = 1'b0;
`endif
  logic [5:0] model_mem [32];
  logic [5:0] sb [$];
  int loaded = 0;
  logic [15:0] exp_cnt = '0;
  int n_cmp = 0, n_bad = 0;
  mccoy_prog_sequencer dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .stop(stop), .step(step), .core_pc(core_pc),
`ifdef MCCOY_SEQ_BREAKPOINT_EN
    .bp_addr(bp_addr), .bp_enable(bp_enable),
`endif
    .core_instr(core_instr), .core_clk_en(core_clk_en), .core_reset(core_reset),
    .busy(busy), .halted(halted), .cycle_cnt(cycle_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic r, input logic e, input logic b, input logic h);
    check({tag, ".core_reset"}, 32'(r === core_reset), 32'd1);
    check({tag, ".core_clk_en"}, 32'(core_clk_en), 32'(e));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".halted"}, 32'(halted), 32'(h));
  endtask
  // one clock: drive pc, push expected fetch, compare it mid-cycle, then advance
  task automatic cyc(input logic [7:0] pc, input bit live, input bit cnt);
    core_pc = pc;
    sb.push_back((live && int'(pc) < loaded) ? model_mem[pc[4:0]] : FILL);
    @(negedge clk);
    check($sformatf("core_instr@pc%0d", pc), 32'(core_instr), 32'(sb.pop_front()));
    @(posedge clk); #1;
    if (cnt && exp_cnt != 16'hFFFF) exp_cnt++;
  endtask
  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data = 6'($urandom);
      @(negedge clk);
      check("load_ready", 32'(load_ready), 32'(loaded != 32));
      if (loaded != 32) begin
        model_mem[loaded] = load_data;
        loaded++;
      end
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    outs("reset", 1, 0, 0, 0);
    check("reset.cycle_cnt", 32'(cycle_cnt), 32'd0);
    check("reset.load_ready", 32'(load_ready), 32'd1);
    cyc(8'd3, 0, 0);
    load_words(33);
    check("full.load_ready", 32'(load_ready), 32'd0);
    start = 1'b1; cyc(8'd0, 0, 0); start = 1'b0; exp_cnt = '0;
    outs("crst", 1, 1, 1, 0);
    cyc(8'd1, 0, 0);
    outs("run", 0, 1, 1, 0);
    for (int p = 0; p < 8; p++) cyc(8'(p), 1, 1);
    cyc(8'd40, 1, 1);
    cyc(8'd41, 1, 1);
    check("run.cycle_cnt", 32'(cycle_cnt), 32'(exp_cnt));
    cyc(8'h07, 1, 1); cyc(8'h07, 1, 1);
    outs("pre_halt", 0, 1, 1, 0);
    cyc(8'h07, 1, 1);
    outs("halt", 0, 0, 0, 1);
    cyc(8'h07, 1, 0); cyc(8'h07, 1, 0);
    check("halt.cycle_cnt", 32'(cycle_cnt), 32'd13);
    stop = 1'b1; cyc(8'h07, 1, 0); stop = 1'b0; loaded = 0;
    outs("halt_stop", 1, 0, 0, 0);
    check("halt_stop.load_ready", 32'(load_ready), 32'd1);
    load_words(3);
    start = 1'b1; cyc(8'd0, 0, 0); start = 1'b0; exp_cnt = '0;
    cyc(8'd0, 0, 0);
    cyc(8'd1, 1, 1); cyc(8'd5, 1, 1); cyc(8'd2, 1, 1); cyc(8'd3, 1, 1);
    stop = 1'b1; cyc(8'd4, 1, 1); stop = 1'b0;
    outs("pause", 0, 0, 0, 0);
    cyc(8'd4, 1, 0); cyc(8'd4, 1, 0);
    check("pause.cycle_cnt", 32'(cycle_cnt), 32'd5);
    step = 1'b1; cyc(8'd4, 1, 0); step = 1'b0;
    outs("step", 0, 1, 1, 0);
    cyc(8'd5, 1, 1);
    outs("post_step", 0, 0, 0, 0);
    check("step.cycle_cnt", 32'(cycle_cnt), 32'd6);
    start = 1'b1; cyc(8'd5, 1, 0); start = 1'b0;
    cyc(8'd6, 1, 1); cyc(8'd6, 1, 1);
    stop = 1'b1; cyc(8'd6, 1, 1);
    outs("stop_over_halt", 0, 0, 0, 0);
    step = 1'b1; cyc(8'd6, 1, 0); stop = 1'b0; step = 1'b0;
    outs("stop_step_idle", 1, 0, 0, 0);
    check("stop_step.cycle_cnt", 32'(cycle_cnt), 32'd9);
    start = 1'b1; cyc(8'd0, 0, 0); start = 1'b0;
    cyc(8'd0, 0, 0); cyc(8'd1, 1, 1); cyc(8'd2, 1, 1);
    outs("pre_midrst", 0, 1, 1, 0);
    reset = 1'b0; cyc(8'd3, 1, 0); cyc(8'd4, 0, 0); reset = 1'b1;
    loaded = 0; exp_cnt = '0;
    outs("mid_reset", 1, 0, 0, 0);
    check("mid_reset.cycle_cnt", 32'(cycle_cnt), 32'd0);
    check("mid_reset.load_ready", 32'(load_ready), 32'd1);
    start = 1'b1; cyc(8'd0, 0, 0); start = 1'b0;
    outs("empty_start", 1, 0, 0, 0);
    load_words(1);
    start = 1'b1; cyc(8'd0, 0, 0); start = 1'b0;
    cyc(8'd0, 0, 0);
    for (int i = 0; i < 65540; i++) begin
      core_pc = 8'(i);
      @(posedge clk); #1;
    end
    exp_cnt = 16'hFFFF;
    check("sat.cycle_cnt", 32'(cycle_cnt), 32'(exp_cnt));
    cyc(8'd200, 1, 1);
    check("sat_hold.cycle_cnt", 32'(cycle_cnt), 32'hFFFF);
    outs("sat_run", 0, 1, 1, 0);
    stop = 1'b1; cyc(8'd201, 1, 1); cyc(8'd201, 1, 0); stop = 1'b0;
    outs("sat_idle", 1, 0, 0, 0);
`ifdef MCCOY_SEQ_BREAKPOINT_EN
    bp_addr = 8'h02; bp_enable = 1'b1;
    start = 1'b1; cyc(8'd0, 0, 0); start = 1'b0; exp_cnt = '0;
    cyc(8'd0, 0, 0);
    cyc(8'd0, 1, 1); cyc(8'd1, 1, 1);
    outs("pre_bp", 0, 1, 1, 0);
    cyc(8'd2, 1, 1);
    outs("bp", 0, 0, 0, 0);
    check("bp.cycle_cnt", 32'(cycle_cnt), 32'(exp_cnt));
    start = 1'b1; cyc(8'd2, 1, 0); start = 1'b0;
    cyc(8'd2, 1, 1);
    outs("bp_resume", 0, 1, 1, 0);
    cyc(8'd3, 1, 1);
    outs("bp_past", 0, 1, 1, 0);
    check("bp_past.cycle_cnt", 32'(cycle_cnt), 32'd5);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
